// File: rtl/branch_redirect_ctrl_pkg.sv
// Shared definitions for the branch redirect controller:
// opcode/func encodings, FSM state type and drain counter width.
package branch_redirect_ctrl_pkg;

    localparam logic [3:0] BRANCH = 4'b0010;

    typedef enum logic [3:0] {
        BF    = 4'd0,
        BT    = 4'd1,
        BEQ   = 4'd2,
        BNE   = 4'd3,
        BLT   = 4'd4,
        BGTE  = 4'd5,
        BLTE  = 4'd6,
        BGT   = 4'd7,
        BEQZ  = 4'd8,
        BNEZ  = 4'd9,
        BLTZ  = 4'd10,
        BGTEZ = 4'd11,
        BLTEZ = 4'd12,
        BGTZ  = 4'd13
    } branch_func_e;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REDIRECT = 2'd1,
        DRAIN    = 2'd2
    } state_e;

    // Wide enough for drain lengths up to 15.
    localparam int DRAIN_W = 4;

endpackage

// File: rtl/branch_redirect_ctrl_if.sv
// EX-stage branch inputs, fetch redirect handshake and status outputs.
// The master is the pipeline/fetch side; the slave is the controller.
interface branch_redirect_ctrl_if #(
    parameter int PC_W  = 32,
    parameter int IMM_W = 16
);
    logic             ex_valid;
    logic [3:0]       ex_opcode;
    logic [PC_W-1:0]  ex_pc;
    logic [IMM_W-1:0] ex_imm;
    logic             taken;
    logic             redirect_ready;

    logic             flush_young;
    logic             fetch_hold;
    logic             redirect_valid;
    logic [PC_W-1:0]  redirect_pc;
    logic             busy;
    logic [31:0]      branch_count;
    logic [31:0]      taken_count;

    modport master (
        output ex_valid, ex_opcode, ex_pc, ex_imm, taken, redirect_ready,
        input  flush_young, fetch_hold, redirect_valid, redirect_pc, busy,
               branch_count, taken_count
    );

    modport slave (
        input  ex_valid, ex_opcode, ex_pc, ex_imm, taken, redirect_ready,
        output flush_young, fetch_hold, redirect_valid, redirect_pc, busy,
               branch_count, taken_count
    );
endinterface

// File: rtl/branch_redirect_ctrl_target.sv
// Combinational branch target: pc + 4 + (sign-extended word offset << 2),
// wrapping modulo 2^PC_W. Shared with the jump path.
module branch_target_calc #(
    parameter int PC_W  = 32,
    parameter int IMM_W = 16
) (
    input  logic [PC_W-1:0]  pc,
    input  logic [IMM_W-1:0] imm,
    output logic [PC_W-1:0]  target
);
    logic [PC_W-1:0] offset;

    assign offset = {{(PC_W-IMM_W){imm[IMM_W-1]}}, imm} << 2;
    assign target = pc + PC_W'(4) + offset;

endmodule

// File: rtl/branch_redirect_ctrl.sv
// Resolves EX-stage branches: counts them, kills wrong-path IF/ID work,
// holds a redirect to fetch until accepted, then drains bubble cycles.
module branch_redirect_ctrl
    import branch_redirect_ctrl_pkg::*;
#(
    parameter int PC_W         = 32,
    parameter int IMM_W        = 16,
    parameter int DRAIN_CYCLES = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    branch_redirect_ctrl_if.slave  bus
);
    state_e              state_q, state_d;
    logic [DRAIN_W-1:0]  drain_q, drain_d;
    logic [PC_W-1:0]     redirect_pc_q;
    logic [PC_W-1:0]     target;
    logic [31:0]         branch_count_q, taken_count_q;
    logic                br_now;

    // Branches seen outside IDLE are on the wrong path and are dropped.
    assign br_now = bus.ex_valid && (bus.ex_opcode == BRANCH) && (state_q == IDLE);

    branch_target_calc #(
        .PC_W  (PC_W),
        .IMM_W (IMM_W)
    ) u_target (
        .pc     (bus.ex_pc),
        .imm    (bus.ex_imm),
        .target (target)
    );

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            drain_q        <= '0;
            redirect_pc_q  <= '0;
            branch_count_q <= '0;
            taken_count_q  <= '0;
        end else begin
            state_q <= state_d;
            drain_q <= drain_d;
            if (br_now) begin
                branch_count_q <= branch_count_q + 32'd1;
                if (bus.taken) begin
                    taken_count_q <= taken_count_q + 32'd1;
                    redirect_pc_q <= target;
                end
            end
        end
    end

    // NOTE: defaults first so every path assigns every output and no latch
    // is inferred.
    always_comb begin
        state_d = state_q;
        drain_d = drain_q;
        case (state_q)
            IDLE: begin
                if (br_now && bus.taken) state_d = REDIRECT;
            end
            REDIRECT: begin
                if (bus.redirect_ready) begin
                    if (DRAIN_CYCLES == 0) begin
                        state_d = IDLE;
                    end else begin
                        state_d = DRAIN;
                        drain_d = DRAIN_W'(DRAIN_CYCLES);
                    end
                end
            end
            DRAIN: begin
                drain_d = drain_q - 1'b1;
                if (drain_q <= DRAIN_W'(1)) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.flush_young    = 1'b0;
        bus.fetch_hold     = 1'b0;
        bus.redirect_valid = 1'b0;
        case (state_q)
            IDLE:     bus.flush_young = br_now && bus.taken;
            REDIRECT: begin
                bus.flush_young    = 1'b1;
                bus.fetch_hold     = 1'b1;
                bus.redirect_valid = 1'b1;
            end
            DRAIN:    bus.flush_young = 1'b1;
            default:  ;
        endcase
    end

    assign bus.busy         = (state_q != IDLE);
    assign bus.redirect_pc  = redirect_pc_q;
    assign bus.branch_count = branch_count_q;
    assign bus.taken_count  = taken_count_q;

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Self-checking bench: directed scenarios then random traffic, all compared
// cycle by cycle against a transaction-level model of the redirect protocol.
module tb_branch_redirect_ctrl;
    import branch_redirect_ctrl_pkg::*;

    localparam int PC_W  = 32;
    localparam int IMM_W = 16;
    localparam int DRAIN = 2;

    logic clk;
    logic reset;

    int checks = 0;
    int errors = 0;

    // Model: an outstanding redirect, the bubbles still owed, last target.
    bit          m_pending;
    int          m_drain_left;
    logic [31:0] m_pc;
    logic [31:0] m_bcnt;
    logic [31:0] m_tcnt;

    branch_redirect_ctrl_if #(.PC_W(PC_W), .IMM_W(IMM_W)) bus ();

    branch_redirect_ctrl #(
        .PC_W         (PC_W),
        .IMM_W        (IMM_W),
        .DRAIN_CYCLES (DRAIN)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed,
                         input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t",
                     tag, observed, expected, $time);
        end
    endtask

    function automatic logic [31:0] ref_target(input logic [31:0] pc,
                                               input logic [15:0] imm);
        longint sum;
        sum = longint'(pc) + 64'sd4 + 64'sd4 * longint'($signed(imm));
        return sum[31:0];
    endfunction

    // Compare DUT against model with the current inputs applied, then advance
    // one clock and move the model across the same edge.
    task automatic step();
        bit busy_e, br;
        #1;
        busy_e = m_pending || (m_drain_left > 0);
        br     = bus.ex_valid && (bus.ex_opcode == BRANCH) && !busy_e;
        if (!reset) begin
            check("busy",       32'(bus.busy),           32'(busy_e));
            check("flush",      32'(bus.flush_young),
                  32'(busy_e || (br && bus.taken)));
            check("hold",       32'(bus.fetch_hold),     32'(m_pending));
            check("rvalid",     32'(bus.redirect_valid), 32'(m_pending));
            check("rpc",        bus.redirect_pc,         m_pc);
            check("bcnt",       bus.branch_count,        m_bcnt);
            check("tcnt",       bus.taken_count,         m_tcnt);
        end
        @(posedge clk);
        if (reset) begin
            m_pending = 0; m_drain_left = 0;
            m_pc = '0; m_bcnt = '0; m_tcnt = '0;
        end else if (m_pending) begin
            if (bus.redirect_ready) begin
                m_pending    = 0;
                m_drain_left = DRAIN;
            end
        end else if (m_drain_left > 0) begin
            m_drain_left--;
        end else if (br) begin
            m_bcnt++;
            if (bus.taken) begin
                m_tcnt++;
                m_pending = 1;
                m_pc      = ref_target(bus.ex_pc, bus.ex_imm);
            end
        end
        #1;
    endtask

    task automatic drive(input bit v, input logic [3:0] op, input logic [31:0] pc,
                         input logic [15:0] imm, input bit tk, input bit rdy,
                         input bit rst);
        bus.ex_valid       = v;
        bus.ex_opcode      = op;
        bus.ex_pc          = pc;
        bus.ex_imm         = imm;
        bus.taken          = tk;
        bus.redirect_ready = rdy;
        reset              = rst;
        step();
    endtask

    task automatic idle_cycle(input bit rdy);
        drive(0, 4'h0, '0, '0, 0, rdy, 0);
    endtask

    task automatic do_reset();
        drive(0, 4'h0, '0, '0, 0, 0, 1);
        drive(0, 4'h0, '0, '0, 0, 0, 1);
    endtask

    initial begin
        m_pending = 0; m_drain_left = 0;
        m_pc = '0; m_bcnt = '0; m_tcnt = '0;

        // Reset state.
        do_reset();
        idle_cycle(0);

        // Not taken: counted, no flush, never busy.
        drive(1, BRANCH, 32'h100, 16'h0003, 0, 0, 0);
        idle_cycle(0);
        check("nt_bcnt", bus.branch_count, 32'd1);
        check("nt_tcnt", bus.taken_count,  32'd0);

        // Taken, fetch accepts at once: 0x100 + 4 + 12 = 0x110.
        drive(1, BRANCH, 32'h100, 16'h0003, 1, 0, 0);
        check("tk_rpc", bus.redirect_pc, 32'h110);
        drive(0, 4'h0, '0, '0, 0, 1, 0);
        idle_cycle(0);
        idle_cycle(0);
        idle_cycle(0);
        check("tk_idle", 32'(bus.busy), 32'd0);
        check("tk_tcnt", bus.taken_count, 32'd1);

        // Backpressure: ready low three cycles, a wrong-path branch in the window.
        drive(1, BRANCH, 32'h100, 16'h0003, 1, 0, 0);
        drive(1, BRANCH, 32'h200, 16'h0010, 1, 0, 0);
        idle_cycle(0);
        idle_cycle(0);
        check("bp_hold", 32'(bus.fetch_hold), 32'd1);
        drive(0, 4'h0, '0, '0, 0, 1, 0);
        repeat (3) idle_cycle(0);
        check("bp_bcnt", bus.branch_count, 32'd3);

        // Negative offset: 0x100 + 4 - 8 = 0xFC.
        drive(1, BRANCH, 32'h100, 16'hFFFE, 1, 1, 0);
        check("neg_rpc", bus.redirect_pc, 32'hFC);
        drive(0, 4'h0, '0, '0, 0, 1, 0);
        repeat (3) idle_cycle(0);

        // Target wraps past 2^32.
        drive(1, BRANCH, 32'hFFFF_FFFC, 16'h0000, 1, 0, 0);
        check("wrap_rpc", bus.redirect_pc, 32'h0);
        drive(0, 4'h0, '0, '0, 0, 1, 0);
        repeat (3) idle_cycle(0);

        // Reset while the redirect is still pending.
        drive(1, BRANCH, 32'h400, 16'h0001, 1, 0, 0);
        idle_cycle(0);
        drive(0, 4'h0, '0, '0, 0, 0, 1);
        check("rst_rvalid", 32'(bus.redirect_valid), 32'd0);
        check("rst_busy",   32'(bus.busy),           32'd0);
        check("rst_bcnt",   bus.branch_count,        32'd0);
        idle_cycle(0);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            logic [3:0] op;
            op = ($urandom_range(0, 3) != 0) ? BRANCH : 4'($urandom_range(0, 15));
            drive(bit'($urandom_range(0, 3) != 0), op, $urandom(),
                  16'($urandom()), bit'($urandom_range(0, 1)),
                  bit'($urandom_range(0, 2) == 0), bit'($urandom_range(0, 199) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/branch_redirect_ctrl.md
Name: branch_redirect_ctrl

Overview:
Sequences control-flow redirection for the 5-stage pipeline once a branch resolves in EX. It consumes the EX-stage instruction fields and the 1-bit taken result from the branch condition evaluator, computes the branch target, and kills wrong-path instructions in IF/ID. It also holds a redirect request to fetch until fetch accepts it, then drains a fixed number of bubble cycles. It keeps 32-bit branch and taken-branch performance counters.

Parameters:
PC_W, 32, PC / target width
IMM_W, 16, branch offset width (signed, word offset)
DRAIN_CYCLES, 2, bubble cycles held after the redirect handshake (range 0..15)

Ports:
clk  input  1  pipeline clock, rising edge
reset  input  1  synchronous, active-high
ex_valid  input  1  EX stage holds a real (non-bubble) instruction
ex_opcode  input  4  EX opcode; 4'b0010 = BRANCH
ex_pc  input  PC_W  PC of the EX instruction
ex_imm  input  IMM_W  signed word offset
taken  input  1  branch condition result for the EX instruction
redirect_ready  input  1  fetch accepts redirect this cycle
flush_young  output  1  kill IF/ID contents at the next edge
fetch_hold  output  1  fetch must not advance PC
redirect_valid  output  1  redirect request pending
redirect_pc  output  PC_W  new fetch PC
busy  output  1  FSM not IDLE
branch_count  output  32  resolved branches (wraps)
taken_count  output  32  taken branches (wraps)

Behaviour:
- Reset, when reset=1 at an edge:
  - state=IDLE; redirect_valid=0; redirect_pc=0; counters=0; drain counter=0.
  - Reset overrides everything, including mid-REDIRECT or mid-DRAIN.
- Branch resolution:
  - br_now = ex_valid & (ex_opcode==4'b0010) & (state==IDLE).
  - Branches arriving while not IDLE are wrong-path. Ignore them; do not count them.
- Target: redirect target = ex_pc + 4 + (sext(ex_imm) << 2), truncated to PC_W, wraps modulo 2^PC_W.
- Counters: on br_now, branch_count += 1. If taken also =1, taken_count += 1. Both wrap 0xFFFFFFFF -> 0.
- FSM states: IDLE, REDIRECT, DRAIN.
- IDLE:
  - If br_now & taken: flush_young=1 combinationally in the same cycle (Mealy).
  - At that edge: capture target into redirect_pc, set redirect_valid=1, go to REDIRECT.
  - If the branch is not taken: no flush; stay in IDLE.
- REDIRECT:
  - Outputs: redirect_valid=1, flush_young=1, fetch_hold=1, redirect_pc stable.
  - On an edge with redirect_ready=1: redirect_valid->0.
    - If DRAIN_CYCLES==0: go to IDLE.
    - Else: load the drain count with DRAIN_CYCLES and go to DRAIN.
  - redirect_ready while redirect_valid=0 is ignored.
- DRAIN:
  - Outputs: flush_young=1, fetch_hold=0 (fetch runs on the correct path), redirect_valid=0.
  - Decrement the count each cycle; at 1 -> go to IDLE. Total of DRAIN_CYCLES cycles in DRAIN.
- busy = (state != IDLE).
- Latency: branch-taken cycle T, then redirect_valid at T+1. With ready=1 at T+1, the total cost is 1 + 1 + DRAIN_CYCLES cycles.
- Outputs outside the above conditions are 0. redirect_pc holds its last captured value.

Decomposition:
- Shared package holds:
  - opcode constant BRANCH=4'b0010 and the branch func codes (BF, BT, BEQ, BNE, BLT, BGTE, BLTE, BGT, BEQZ, BNEZ, BLTZ, BGTEZ, BLTEZ, BGTZ);
  - state encoding IDLE=2'd0, REDIRECT=2'd1, DRAIN=2'd2.
- One natural sub-module: branch_target_calc, a combinational PC+4+offset adder, reusable by the jump path.

Test Plan:
- Not taken: ex_pc=0x100, BRANCH, taken=0 -> no flush; branch_count=1, taken_count=0; busy stays 0.
- Taken, ready immediate: ex_pc=0x100, imm=0x0003, taken=1, ready=1 at T+1 -> flush_young at T. At T+1, redirect_valid=1 and redirect_pc=0x110. DRAIN at T+2..T+3, IDLE at T+4; taken_count=1.
- Backpressure: same branch, ready low 3 cycles -> redirect_valid and fetch_hold held T+1..T+4 with redirect_pc stable. A branch presented during that window is not counted.
- Negative offset and wrap:
  - ex_pc=0x100, imm=0xFFFE -> redirect_pc=0xFC.
  - ex_pc=0xFFFFFFFC, imm=0 -> redirect_pc=0x0.
- Reset mid-REDIRECT: assert reset at T+2 -> next cycle state IDLE, redirect_valid=0, counters=0.
- Counter wrap: preload via 2^32-1 taken branches (or a forced value) -> next taken branch gives 0.
